// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM pipeline stage and the data-memory
// responder. The pipeline side is the master, the responder is the slave.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall_o;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall_o
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, performs a byte/half/word access on a word-organised
// little-endian array and returns a one-cycle response pulse.
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem [0:(2**ADDR_W)-1];

  logic [ADDR_W-1:0]   word_idx;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rd_shift;
  logic [DATA_W-1:0]   load_data;
  logic                access_err;
  logic [3:0]          byte_en;
  logic [DATA_W-1:0]   wr_lanes;
  logic [DATA_W-1:0]   wr_word;
  logic                mem_we;
  logic                ready;
  logic                accept;

  // Decode the latched request: error check, load extraction and store lane merge
  always_comb begin
    word_idx   = addr_q[ADDR_W+1:2];
    rd_word    = mem[word_idx];
    access_err = (size_q == 2'b11) ||
                 ((size_q == 2'b01) && addr_q[0]) ||
                 ((size_q == 2'b10) && (addr_q[1:0] != 2'b00)) ||
                 (|addr_q[31:ADDR_W+2]);
    rd_shift   = rd_word >> {addr_q[1:0], 3'b000};
    load_data  = '0;
    byte_en    = 4'b0000;
    wr_lanes   = wdata_q;
    case (size_q)
      2'b00: begin
        load_data = uns_q ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
        byte_en   = 4'b0001 << addr_q[1:0];
        wr_lanes  = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        load_data = uns_q ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
        byte_en   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_lanes  = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        load_data = rd_word;
        byte_en   = 4'b1111;
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = byte_en[i] ? wr_lanes[8*i +: 8] : rd_word[8*i +: 8];
    end
    mem_we = (state_q == ACCESS) && we_q && !access_err;
  end

  // Storage array write port; deliberately not reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_idx] <= wr_word;
    end
  end

  // Next-state logic: acceptance, wait countdown, access and response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ready   = (state_q == IDLE) || (state_q == RESP);
    accept  = bus.req_valid && ready;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end else if (state_q == RESP) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: begin
        err_d   = access_err;
        rdata_d = (access_err || we_q) ? '0 : load_data;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset aborts any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.stall_o   = bus.req_valid && (state_q != RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (WAIT_CYCLES=2 and 0) share the
// request fields; a table of directed vectors, hand-written multi-cycle
// sequences and a randomized run against a byte-array reference model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        valid2, valid0, use0;
  logic        t_we, t_uns;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata;

  dmem_responder_if bus2();
  dmem_responder_if bus0();

  assign bus2.req_valid    = valid2;
  assign bus2.req_we       = t_we;
  assign bus2.req_size     = t_size;
  assign bus2.req_unsigned = t_uns;
  assign bus2.req_addr     = t_addr;
  assign bus2.req_wdata    = t_wdata;
  assign bus0.req_valid    = valid0;
  assign bus0.req_we       = t_we;
  assign bus0.req_size     = t_size;
  assign bus0.req_unsigned = t_uns;
  assign bus0.req_addr     = t_addr;
  assign bus0.req_wdata    = t_wdata;

  dmem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));
  dmem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  wire        o_ready = use0 ? bus0.req_ready : bus2.req_ready;
  wire        o_rsp   = use0 ? bus0.rsp_valid : bus2.rsp_valid;
  wire [31:0] o_rdata = use0 ? bus0.rsp_rdata : bus2.rsp_rdata;
  wire        o_err   = use0 ? bus0.rsp_err   : bus2.rsp_err;
  wire        o_stall = use0 ? bus0.stall_o   : bus2.stall_o;

  int total_checks  = 0;
  int passed_checks = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] ref_mem [0:4095];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic addVec(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // Issue one request on the selected instance (called at a negedge);
  // returns response fields, latency in negedges after acceptance, and
  // whether req_ready was low while busy and high in the response cycle.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output int lat, output logic ready_ok);
    int wait_n;
    t_we = we; t_size = size; t_uns = uns; t_addr = addr; t_wdata = wdata;
    if (use0) valid0 = 1'b1; else valid2 = 1'b1;
    wait_n = 0;
    while (!o_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    @(negedge clk);
    valid2 = 1'b0;
    valid0 = 1'b0;
    lat = 1;
    ready_ok = 1'b1;
    while (!o_rsp && lat < 50) begin
      if (o_ready) ready_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!o_ready) ready_ok = 1'b0;
    rdata = o_rdata;
    err   = o_err;
  endtask

  // Reference behaviour on a flat byte array (4096 bytes = 1024 words)
  task automatic modelReq(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    int n;
    int a;
    logic [31:0] v;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || (addr >= 32'd4096);
    rdata = 32'h0;
    if (!err) begin
      n = 1 << size;
      a = int'(addr);
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[a + i] = 8'(wdata >> (8 * i));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (n < 4 && !uns && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rdata = v;
      end
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] rd, exp_rd, a, wd;
    logic        er, exp_er, rok, saw, we;
    logic [1:0]  sz;
    logic        un;
    int          lat;

    rst_n = 1'b0; valid2 = 1'b0; valid0 = 1'b0; use0 = 1'b0;
    t_we = 1'b0; t_size = 2'b00; t_uns = 1'b0; t_addr = 32'h0; t_wdata = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", o_ready, 1);
    checkOutput("reset_rsp_valid", o_rsp, 0);
    checkOutput("reset_rdata", o_rdata, 0);
    checkOutput("reset_err", o_err, 0);
    checkOutput("reset_stall", o_stall, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors on the WAIT_CYCLES=2 instance
    addVec(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    addVec(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    addVec(1, 2'b00, 0, 32'h13, 32'h80, 32'h0, 0);
    addVec(0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    addVec(0, 2'b00, 1, 32'h13, 32'h0, 32'h00000080, 0);
    addVec(0, 2'b10, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0);
    addVec(1, 2'b01, 0, 32'h12, 32'h1234, 32'h0, 0);
    addVec(0, 2'b01, 0, 32'h12, 32'h0, 32'h00001234, 0);
    addVec(0, 2'b10, 0, 32'h10, 32'h0, 32'h1234BEEF, 0);
    addVec(1, 2'b10, 0, 32'h11, 32'h55555555, 32'h0, 1);
    addVec(0, 2'b01, 0, 32'h01, 32'h0, 32'h0, 1);
    addVec(0, 2'b11, 0, 32'h00, 32'h0, 32'h0, 1);
    addVec(1, 2'b10, 0, 32'h1000, 32'h66666666, 32'h0, 1);
    addVec(0, 2'b10, 0, 32'h10, 32'h0, 32'h1234BEEF, 0);
    addVec(1, 2'b10, 0, 32'h20, 32'hA5C37F01, 32'h0, 0);
    addVec(0, 2'b01, 1, 32'h22, 32'h0, 32'h0000A5C3, 0);
    addVec(0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFFA5C3, 0);
    addVec(0, 2'b00, 0, 32'h21, 32'h0, 32'h0000007F, 0);
    addVec(0, 2'b00, 1, 32'h20, 32'h0, 32'h00000001, 0);
    addVec(0, 2'b10, 1, 32'h20, 32'h0, 32'hA5C37F01, 0);
    addVec(1, 2'b01, 0, 32'h20, 32'hFFFF5678, 32'h0, 0);
    addVec(1, 2'b00, 0, 32'h22, 32'hAAAAAA99, 32'h0, 0);
    addVec(0, 2'b10, 0, 32'h20, 32'h0, 32'hA5995678, 0);
    addVec(0, 2'b00, 0, 32'h22, 32'h0, 32'hFFFFFF99, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    rd, er, lat, rok);
      checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      checkOutput($sformatf("vec%0d_ready", i), 32'(rok), 32'd1);
    end

    // Reset pulsed while a store waits: no response, write never lands
    applyStimulus(1, 2'b10, 0, 32'h30, 32'hCAFEF00D, rd, er, lat, rok);
    t_we = 1'b1; t_size = 2'b10; t_uns = 1'b0; t_addr = 32'h30; t_wdata = 32'h0BADF00D;
    valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    checkOutput("midwait_ready", o_ready, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", o_ready, 1);
    checkOutput("abort_rsp_valid", o_rsp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (o_rsp) saw = 1'b1;
    end
    checkOutput("abort_no_rsp", 32'(saw), 0);
    applyStimulus(0, 2'b10, 0, 32'h30, 32'h0, rd, er, lat, rok);
    checkOutput("abort_old_data", rd, 32'hCAFEF00D);

    // Back-to-back on the WAIT_CYCLES=0 instance, request held valid through RESP
    use0 = 1'b1;
    applyStimulus(1, 2'b10, 0, 32'h40, 32'h11223344, rd, er, lat, rok);
    checkOutput("w0_store_latency", 32'(lat), 32'd2);
    t_we = 1'b0; t_size = 2'b10; t_uns = 1'b0; t_addr = 32'h40; t_wdata = 32'h0;
    valid0 = 1'b1;
    @(negedge clk);
    checkOutput("b2b_a_ready", o_ready, 0);
    checkOutput("b2b_a_stall", o_stall, 1);
    checkOutput("b2b_a_busy_rsp", o_rsp, 0);
    t_size = 2'b00; t_uns = 1'b1; t_addr = 32'h43;
    @(negedge clk);
    checkOutput("b2b_a_rsp", o_rsp, 1);
    checkOutput("b2b_a_rdata", o_rdata, 32'h11223344);
    checkOutput("b2b_a_resp_stall", o_stall, 0);
    checkOutput("b2b_a_resp_ready", o_ready, 1);
    @(negedge clk);
    checkOutput("b2b_b_busy_rsp", o_rsp, 0);
    checkOutput("b2b_b_stall", o_stall, 1);
    t_size = 2'b01; t_uns = 1'b0; t_addr = 32'h42;
    @(negedge clk);
    checkOutput("b2b_b_rsp", o_rsp, 1);
    checkOutput("b2b_b_rdata", o_rdata, 32'h00000011);
    checkOutput("b2b_b_resp_stall", o_stall, 0);
    @(negedge clk);
    checkOutput("b2b_c_stall", o_stall, 1);
    valid0 = 1'b0;
    @(negedge clk);
    checkOutput("b2b_c_rsp", o_rsp, 1);
    checkOutput("b2b_c_rdata", o_rdata, 32'h00001122);
    @(negedge clk);
    checkOutput("b2b_idle_rsp", o_rsp, 0);
    use0 = 1'b0;

    // Randomized run on the WAIT_CYCLES=2 instance; preload region 0x100..0x17F
    for (int w = 0; w < 32; w++) begin
      wd = $urandom;
      a  = 32'h100 + 32'(4 * w);
      modelReq(1, 2'b10, 0, a, wd, exp_rd, exp_er);
      applyStimulus(1, 2'b10, 0, a, wd, rd, er, lat, rok);
      checkOutput("preload_err", 32'(er), 32'(exp_er));
    end
    for (int k = 0; k < 150; k++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      un = 1'($urandom_range(0, 1));
      wd = $urandom;
      a  = 32'h100 + 32'($urandom_range(0, 127));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(12, 31));
      modelReq(we, sz, un, a, wd, exp_rd, exp_er);
      applyStimulus(we, sz, un, a, wd, rd, er, lat, rok);
      checkOutput($sformatf("rand%0d_rdata", k), rd, exp_rd);
      checkOutput($sformatf("rand%0d_err", k), 32'(er), 32'(exp_er));
      checkOutput($sformatf("rand%0d_latency", k), 32'(lat), 32'd4);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving load/store requests issued by the MEM pipeline stage.
- Accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs byte/half/word stores with lane enables, and byte/half/word loads with sign or zero extension.
- Returns a one-cycle response pulse and drives a stall for the pipeline while a request is outstanding.

Parameters:
- DATA_W, 32: data bus width; fixed at 32, since byte-lane logic assumes 4 lanes.
- ADDR_W, 10: word-address width; the storage array holds 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2: extra cycles between acceptance and access; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected; valid with rsp_valid.
- stall_o  out  1  pipeline hold request.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; wait counter = 0; latched request = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 1.
  - The storage array is not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - req_ready = 1 in IDLE and RESP, 0 in WAIT and ACCESS.
  - Accept when req_valid && req_ready at a rising edge; latch we/size/unsigned/addr/wdata.
  - On accept: go to WAIT with counter = WAIT_CYCLES-1 when WAIT_CYCLES > 0; go to ACCESS directly when WAIT_CYCLES = 0.
  - WAIT: decrement the counter each cycle; at 0 go to ACCESS.
  - ACCESS: perform the memory operation, register rsp_rdata/rsp_err, go to RESP.
  - RESP: rsp_valid = 1 for exactly this cycle. If a new request is accepted here, go to WAIT or ACCESS; otherwise go to IDLE.
- Latency:
  - Request accepted at edge T gives rsp_valid high in the cycle after edge T+1+WAIT_CYCLES.
  - Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Error conditions (rsp_err = 1, no memory write, rsp_rdata = 0):
  - size = 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 00;
  - any req_addr[31:ADDR_W+2] bit set.
- Stores: little-endian; word index = addr[ADDR_W+1:2].
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - Word: all four lanes.
  - Untouched lanes keep their value.
- Loads: the selected byte or half is right-aligned, then sign-extended from bit 7/15, or zero-extended if req_unsigned. Word loads are ignored by req_unsigned.
- stall_o = req_valid && !rsp_valid (combinational). The pipeline advances on the cycle the response arrives.
- Inputs changing after acceptance do not affect the in-flight request.
- Reset mid-operation aborts the request.
  - No rsp_valid is produced.
  - A write already performed in ACCESS persists; a write not yet reached never occurs.
- rsp_rdata and rsp_err hold their last values outside RESP; only rsp_valid qualifies them.

Test Plan:
- Reset, then word store 0xDEADBEEF @0x10 followed by a word load @0x10 (WAIT_CYCLES=2) -> rsp_valid 4 cycles after each accept edge; load rsp_rdata = 0xDEADBEEF, rsp_err = 0; req_ready low in WAIT/ACCESS.
- Byte store 0x80 @0x13, then loads: signed byte @0x13 -> 0xFFFFFF80; unsigned byte @0x13 -> 0x00000080; word @0x10 -> 0x80ADBEEF.
- Half store 0x1234 @0x12, then signed half load @0x12 -> 0x00001234; word load @0x10 -> 0x1234BEEF.
- Word store @0x11, half load @0x01, size 11 @0x0, word store @0x1000 (ADDR_W=10) -> rsp_err = 1 and rsp_rdata = 0 each time; a word load @0x10 afterwards still returns its prior value.
- WAIT_CYCLES=0 with a second request held valid through RESP -> accepted in RESP; responses 2 cycles apart; stall_o low only in the RESP cycles.
- Word store accepted, then rst_n pulsed low during WAIT -> no rsp_valid; req_ready = 1 immediately; a load of that address returns the old data.
